// File: rtl/pmem_arbiter_fsm_pkg.sv
// Shared types and width defaults for the pmem arbiter.
package pmem_arb_pkg;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP, HOLDOFF} arb_state_t;
   typedef enum logic {REQ_I, REQ_D} req_id_t;
endpackage

// File: rtl/pmem_arbiter_fsm_if.sv
// Cache-side and memory-side signal bundle around the arbiter.
interface pmem_arbiter_fsm_if;
   import pmem_arb_pkg::*;

   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic              i_resp;
   logic [LINE_W-1:0] i_rdata;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic              d_resp;
   logic [LINE_W-1:0] d_rdata;

   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_resp;
   logic [LINE_W-1:0] pmem_rdata;

   // master: the arbiter, which owns the pmem command and the cache responses
   modport master (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_resp, pmem_rdata,
      output i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport slave (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_resp, pmem_rdata,
      input  i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/pmem_arbiter_fsm_rr_pick2.sv
// Two-way round-robin pick with optional masking of the last winner.
module rr_pick2
   import pmem_arb_pkg::*;
(
   input  logic    req_i_i,
   input  logic    req_d_i,
   input  logic    mask_en_i,
   input  req_id_t last_i,
   output logic    vld_o,
   output req_id_t gnt_o
);
   logic elig_i, elig_d;

   // While masked, the requester just served may still show a stale request.
   assign elig_i = req_i_i & ~(mask_en_i & (last_i == REQ_I));
   assign elig_d = req_d_i & ~(mask_en_i & (last_i == REQ_D));
   assign vld_o  = elig_i | elig_d;

   always_comb begin
      gnt_o = REQ_D;
      if (elig_i && elig_d) gnt_o = (last_i == REQ_I) ? REQ_D : REQ_I;
      else if (elig_i)      gnt_o = REQ_I;
   end
endmodule

// File: rtl/pmem_arbiter_fsm.sv
// Shares the single pmem port between I-cache and D-cache.
// The winner is latched at grant; every output comes straight from a flop.
module pmem_arbiter_fsm
   import pmem_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   pmem_arbiter_fsm_if.master bus
);
   arb_state_t        state_q;
   req_id_t           last_q;
   logic              pmem_read_q, pmem_write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              i_resp_q, d_resp_q;
   logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
   logic              gnt_vld;
   req_id_t           gnt_id;

   rr_pick2 u_pick (
      .req_i_i   (bus.i_read),
      .req_d_i   (bus.d_read | bus.d_write),
      .mask_en_i (state_q == HOLDOFF),
      .last_i    (last_q),
      .vld_o     (gnt_vld),
      .gnt_o     (gnt_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_q       <= REQ_D;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         i_resp_q     <= 1'b0;
         d_resp_q     <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         i_resp_q <= 1'b0;
         d_resp_q <= 1'b0;
         unique case (state_q)
            IDLE, HOLDOFF: begin
               state_q <= IDLE;
               if (gnt_vld) begin
                  last_q <= gnt_id;
                  if (gnt_id == REQ_I) begin
                     state_q      <= BUSY_I;
                     addr_q       <= bus.i_addr;
                     pmem_read_q  <= 1'b1;
                     pmem_write_q <= 1'b0;
                  end else begin
                     // read+write together is a protocol error; the write wins
                     state_q      <= BUSY_D;
                     addr_q       <= bus.d_addr;
                     wdata_q      <= bus.d_wdata;
                     pmem_read_q  <= ~bus.d_write;
                     pmem_write_q <= bus.d_write;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               if (bus.pmem_resp) begin
                  state_q      <= RESP;
                  pmem_read_q  <= 1'b0;
                  pmem_write_q <= 1'b0;
                  if (state_q == BUSY_I) begin
                     i_rdata_q <= bus.pmem_rdata;
                     i_resp_q  <= 1'b1;
                  end else begin
                     d_rdata_q <= bus.pmem_rdata;
                     d_resp_q  <= 1'b1;
                  end
               end
            end
            RESP:    state_q <= HOLDOFF;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.pmem_read    = pmem_read_q;
   assign bus.pmem_write   = pmem_write_q;
   assign bus.pmem_address = addr_q;
   assign bus.pmem_wdata   = wdata_q;
   assign bus.i_resp       = i_resp_q;
   assign bus.i_rdata      = i_rdata_q;
   assign bus.d_resp       = d_resp_q;
   assign bus.d_rdata      = d_rdata_q;
endmodule

// File: doc/pmem_arbiter_fsm.md
# pmem_arbiter_fsm

Registered, starvation-free arbiter that shares the single physical-memory port between the instruction cache (read-only) and the data cache (read/write). It sits between the two cache controllers and main memory. It latches the winning request and drives pmem from flops until pmem_resp. It then returns a one-cycle response with registered line data to the winner only.

## Interface
- ADDR_W, 32, address width
- LINE_W, 256, cache-line width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_read  in  1  I-cache line-fill request; held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_resp  out  1  one-cycle completion pulse to I-cache
- i_rdata  out  LINE_W  fill data; valid while i_resp=1
- d_read, d_write  in  1 each  D-cache fill / writeback request; held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  writeback line
- d_resp  out  1  one-cycle completion pulse to D-cache
- d_rdata  out  LINE_W  fill data; valid while d_resp=1
- pmem_read, pmem_write  out  1 each  memory command; held until pmem_resp
- pmem_address  out  ADDR_W  latched address
- pmem_wdata  out  LINE_W  latched write data
- pmem_resp  in  1  memory completion, one cycle
- pmem_rdata  in  LINE_W  valid with pmem_resp

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP, HOLDOFF.
- IDLE: only one requester pending -> grant it. Both pending -> grant the one not served last (last_grant flop, reset = D, so I wins the first tie). Grant latches addr, wdata and command into flops.
- d_read and d_write both high is a protocol error; serviced as a write.
- BUSY_x: pmem command held constant. Requester inputs are ignored, so a mid-transaction input change has no effect. On pmem_resp: capture pmem_rdata into the winner's rdata flop and go to RESP.
- RESP: the winner's resp=1 for exactly this cycle; pmem_read/pmem_write=0. Go to HOLDOFF.
- HOLDOFF: one cycle in which the just-served requester is masked, because its request may still be high for one cycle. The other requester, if pending, is granted directly; otherwise go to IDLE.
- The loser of a tie is granted next, so it waits at most one transaction.
- rdata flops hold their value after RESP. Contents outside resp cycles are don't-care.

## Timing
- Reset (asynchronous, immediate): state=IDLE, last_grant=D, all resp/pmem_read/pmem_write=0, pmem_address=0, pmem_wdata=0, rdata flops=0.
- All outputs are registered; there is no combinational path from any input to any output.
- Request seen in IDLE at edge t -> pmem command high from t+1.
- pmem_resp at edge k -> requester resp high during cycle k+1.
- Next grant starts no earlier than k+3 (RESP, HOLDOFF, then command).
- Uncontended throughput: one transaction per (memory latency + 3) cycles.
- pmem_resp outside BUSY_x is ignored.
- Reset mid-transaction abandons the pmem command immediately. The memory model must tolerate a dropped command.

## Structure
- Shared package pmem_arb_pkg holds the state enum (arb_state_t), the requester enum (req_id_t: REQ_I, REQ_D), and the LINE_W/ADDR_W defaults.
- A single FSM module; no sub-module is needed.
- Optional: factor the tie-break and HOLDOFF masking into rr_pick2, a combinational 2-way round-robin with last_grant input.

## Test plan
- I-only read, addr 0x0000_1000; memory responds 5 cycles after command with 256'hA5... -> pmem_read rises 1 cycle after i_read; i_resp for 1 cycle with i_rdata=256'hA5...; d_resp stays 0.
- D write, addr 0x0000_2000, wdata 256'h1234...; d_wdata changed mid-transaction -> pmem_write high with the latched 256'h1234... until pmem_resp; d_resp pulses once.
- I and D raised on the same cycle after reset -> I served first. D is granted in HOLDOFF (command at k+3), not I a second time.
- Two back-to-back ties -> grants alternate I, D, I, D; no requester is served twice while the other waits.
- Requester keeps its request high for 1 cycle after resp -> no duplicate pmem transaction is issued.
- rst_n asserted during BUSY_D -> pmem_write drops asynchronously. After release, a new I read completes normally.
